// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM states for the
// iterative multiply/divide sequencer.
package muldiv_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request, shared-ALU and result bundle between the EX stage
// and the multiply/divide sequencer.
interface muldiv_ctrl_if #(
   parameter int XLEN = 32
) ();

   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic            flush;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_control;
   logic            alu_own;
   logic            busy;
   logic            done;
   logic            div_zero;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val, flush, alu_result,
      input  alu_a, alu_b, alu_control, alu_own,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, flush, alu_result,
      output alu_a, alu_b, alu_control, alu_own,
      output busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/muldiv_signfix.sv
// Operand absolute values on entry and two's-complement
// correction of product / quotient / remainder on exit.
module muldiv_signfix #(
   parameter int XLEN = 32
) (
   input  logic            sgn,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   input  logic            is_div,
   input  logic            neg_res,
   input  logic            neg_rem,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] sreg,
   output logic            rs_neg,
   output logic            rt_neg,
   output logic [XLEN-1:0] rs_abs,
   output logic [XLEN-1:0] rt_abs,
   output logic [XLEN-1:0] fix_hi,
   output logic [XLEN-1:0] fix_lo
);

   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;

   assign rs_neg = sgn & rs_val[XLEN-1];
   assign rt_neg = sgn & rt_val[XLEN-1];
   assign rs_abs = rs_neg ? -rs_val : rs_val;
   assign rt_abs = rt_neg ? -rt_val : rt_val;

   assign prod     = {acc, sreg};
   assign prod_fix = neg_res ? -prod : prod;

   always_comb begin
      fix_hi = prod_fix[2*XLEN-1:XLEN];
      fix_lo = prod_fix[XLEN-1:0];
      if (is_div) begin
         fix_hi = neg_rem ? -acc : acc;
         fix_lo = neg_res ? -sreg : sreg;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer borrowing the shared ALU.
// MULDIV_ZERO_SKIP_EN: multiply by zero skips the iterations.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input logic          clk,
   input logic          reset,
   muldiv_ctrl_if.slave bus
);

   state_e state;
   state_e state_nx;

   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  acc;
   logic [XLEN-1:0]  sreg;
   logic [XLEN-1:0]  opnd;
   logic [XLEN-1:0]  hi_q;
   logic [XLEN-1:0]  lo_q;
   logic             is_div;
   logic             neg_res;
   logic             neg_rem;
   logic             dz;

   logic            rs_neg;
   logic            rt_neg;
   logic [XLEN-1:0] rs_abs;
   logic [XLEN-1:0] rt_abs;
   logic [XLEN-1:0] fix_hi;
   logic [XLEN-1:0] fix_lo;

   logic            go;
   logic            div0;
   logic            zskip;
   logic            carry;
   logic            rem_msb;
   logic [XLEN-1:0] rem_sh;
   logic            accept;

   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_control;
   logic            alu_own;

   muldiv_signfix #(.XLEN(XLEN)) u_signfix (
      .sgn     (bus.op[0]),
      .rs_val  (bus.rs_val),
      .rt_val  (bus.rt_val),
      .is_div  (is_div),
      .neg_res (neg_res),
      .neg_rem (neg_rem),
      .acc     (acc),
      .sreg    (sreg),
      .rs_neg  (rs_neg),
      .rt_neg  (rt_neg),
      .rs_abs  (rs_abs),
      .rt_abs  (rt_abs),
      .fix_hi  (fix_hi),
      .fix_lo  (fix_lo)
   );

   assign go   = bus.start & ~bus.flush;
   assign div0 = bus.op[1] & (bus.rt_val == '0);

`ifdef MULDIV_ZERO_SKIP_EN
   assign zskip = ~bus.op[1] &
                  ((bus.rs_val == '0) | (bus.rt_val == '0));
`else
   assign zskip = 1'b0;
`endif

   assign carry   = bus.alu_result < acc;
   assign rem_msb = acc[XLEN-1];
   assign rem_sh  = {acc[XLEN-2:0], sreg[XLEN-1]};
   assign accept  = rem_msb | (rem_sh >= opnd);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (go) state_nx = (div0 | zskip) ? S_FIX : S_CALC;
         end
         S_CALC: begin
            if (bus.flush)      state_nx = S_IDLE;
            else if (cnt == '0) state_nx = S_FIX;
         end
         S_FIX:  state_nx = bus.flush ? S_IDLE : S_DONE;
         S_DONE: state_nx = S_IDLE;
      endcase
   end

   // Early-exit cases preload {acc,sreg} so FIX writes them unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         acc     <= '0;
         sreg    <= '0;
         opnd    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         dz      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (go) begin
                  is_div <= bus.op[1];
                  cnt    <= '1;
                  dz     <= div0;
                  if (div0) begin
                     acc     <= bus.rs_val;
                     sreg    <= '1;
                     opnd    <= '0;
                     neg_res <= 1'b0;
                     neg_rem <= 1'b0;
                  end else if (zskip) begin
                     acc     <= '0;
                     sreg    <= '0;
                     opnd    <= '0;
                     neg_res <= 1'b0;
                     neg_rem <= 1'b0;
                  end else begin
                     acc     <= '0;
                     sreg    <= bus.op[1] ? rs_abs : rt_abs;
                     opnd    <= bus.op[1] ? rt_abs : rs_abs;
                     neg_res <= rs_neg ^ rt_neg;
                     neg_rem <= rs_neg;
                  end
               end
            end
            S_CALC: begin
               if (!bus.flush) begin
                  cnt <= cnt - 1'b1;
                  if (is_div) begin
                     if (accept) begin
                        acc  <= bus.alu_result;
                        sreg <= {sreg[XLEN-2:0], 1'b1};
                     end else begin
                        acc  <= rem_sh;
                        sreg <= {sreg[XLEN-2:0], 1'b0};
                     end
                  end else if (sreg[0]) begin
                     acc  <= {carry, bus.alu_result[XLEN-1:1]};
                     sreg <= {bus.alu_result[0], sreg[XLEN-1:1]};
                  end else begin
                     acc  <= {1'b0, acc[XLEN-1:1]};
                     sreg <= {acc[0], sreg[XLEN-1:1]};
                  end
               end
            end
            S_FIX: begin
               if (!bus.flush) begin
                  hi_q <= fix_hi;
                  lo_q <= fix_lo;
               end
            end
            S_DONE: ;
         endcase
      end
   end

   always_comb begin
      alu_a       = '0;
      alu_b       = '0;
      alu_control = ALU_ADD;
      alu_own     = 1'b0;
      if (state == S_CALC) begin
         alu_own = 1'b1;
         alu_b   = opnd;
         if (is_div) begin
            alu_a       = rem_sh;
            alu_control = ALU_SUB;
         end else begin
            alu_a = acc;
         end
      end
   end

   assign bus.alu_a       = alu_a;
   assign bus.alu_b       = alu_b;
   assign bus.alu_control = alu_control;
   assign bus.alu_own     = alu_own;
   assign bus.busy        = state != S_IDLE;
   assign bus.done        = state == S_DONE;
   assign bus.div_zero    = (state == S_DONE) & dz;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage.
- Borrows the shared 32-bit ALU for 32 cycles: shift-add for multiply, restoring subtract for divide.
- Holds HI/LO and stalls the pipeline through `busy`.
- EX-stage operand mux selects this block's ALU inputs while `alu_own`=1.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- rs_val  in  XLEN  multiplicand / dividend.
- rt_val  in  XLEN  multiplier / divisor.
- flush  in  1  abort in-flight operation.
- alu_result  in  XLEN  shared ALU output.
- alu_a  out  XLEN  ALU operand A.
- alu_b  out  XLEN  ALU operand B.
- alu_control  out  4  ALU op code.
- alu_own  out  1  block owns the ALU this cycle.
- busy  out  1  state != IDLE; stalls IF/ID/EX.
- done  out  1  one-cycle pulse; hi/lo valid.
- div_zero  out  1  pulses with done when DIV/DIVU had rt_val=0.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

Behaviour:
Reset (sync, priority over everything, also mid-operation):
- state=IDLE; hi=lo=0; busy=done=div_zero=alu_own=0.
- alu_a=alu_b=0; alu_control=ALU_ADD.

States: IDLE, CALC, FIX, DONE.
- IDLE→CALC on start. Latch abs(rs), abs(rt) (abs only for MULT/DIV), result-sign and remainder-sign. Load counter=31. Clear accumulator.
- Divide with rt_val=0 → DONE directly: hi=rs_val, lo=32'hFFFF_FFFF, div_zero=1.
- CALC: alu_own=1; one iteration per cycle; counter decrements; at 0 → FIX.
- Multiply iteration:
  - alu_a=acc_hi, alu_b=mcand, alu_control=ALU_ADD.
  - carry=(alu_result < alu_a) unsigned.
  - If mplier LSB=1, {carry,alu_result,mplier} >> 1; else {0,acc_hi,mplier} >> 1.
  - Product accumulates in {acc_hi, mplier}.
- Divide iteration:
  - {rem_msb,rem,quo} << 1, shifting in 0.
  - alu_a=shifted rem, alu_b=divisor, alu_control=ALU_SUB.
  - Accept if rem_msb=1 or alu_a>=alu_b unsigned: rem=alu_result, quo LSB=1. Otherwise restore.
- FIX: alu_own=0. Negate locally (two's complement):
  - MULT: 64-bit product if signs differ.
  - DIV: quotient if signs differ; remainder if dividend negative.
  - Write hi (product high / remainder) and lo (product low / quotient).
- DONE: done=1 for exactly 1 cycle; hi/lo already updated; → IDLE.
- Latency: start at cycle 0 → done at cycle 34. busy high cycles 1..34; done and busy fall together at cycle 35.
- start while busy ignored, no queueing.
- flush in CALC/FIX → IDLE next cycle; hi/lo keep previous values; no done pulse.
- flush and start in same IDLE cycle: flush wins, start dropped.
- Outside CALC: alu_a=alu_b=0, alu_control=ALU_ADD.
- Overflow case: DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.

Optional Feature:
MULDIV_ZERO_SKIP_EN
- With: MULT/MULTU with either operand 0 goes IDLE→DONE; hi=lo=0; done at cycle 2.
- Without: always the full 34-cycle path.

Decomposition:
- Shared package muldiv_pkg:
  - ALU code constants ALU_ADD=4'b0010, ALU_SUB=4'b0110 (must match the ALU encoding).
  - op encodings OP_MULTU..OP_DIV.
  - state enum.
- Sub-module muldiv_signfix: combinational abs/negate for operands and results, used in IDLE and FIX.
- FSM, counter and shift registers stay in muldiv_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done at cycle 34; alu_own high cycles 1..32.
- MULT -3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU 100/7 → lo=14, hi=2.
- DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 → done at cycle 2, div_zero=1, hi=5, lo=0xFFFFFFFF.
- MULTU 6×7 (hi=0, lo=42), then a second op:
  - start DIVU at cycle 5 of the second op → ignored.
  - flush at cycle 10 → busy=0 at cycle 11, no done, hi=0/lo=42 retained.
  - reset at cycle 20 of a new op → all outputs 0.
